// File: rtl/wb_forward_pipe_pkg.sv
// wb_forward_pipe_pkg: word/register types and the EX/MEM and MEM/WB pipeline register layouts
package wb_forward_pipe_pkg;
  typedef logic [31:0] word_t;
  typedef logic [4:0]  regbits_t;
  typedef struct packed {
    logic     valid;
    logic     regWEN;
    regbits_t wsel;
    word_t    port_o;
    word_t    store;
    logic     dREN;
    logic     dWEN;
    logic     halt;
  } exmem_t;
  typedef struct packed {
    logic     valid;
    logic     regWEN;
    regbits_t wsel;
    word_t    wdat;
  } memwb_t;
endpackage

// File: rtl/wb_forward_pipe.sv
// wb_forward_pipe: EX/MEM + MEM/WB registers, dmem handshake with EX stall, forwarding fields, sticky halt and wait timeout
module wb_forward_pipe
  import wb_forward_pipe_pkg::*;
#(
  parameter int WAIT_LIMIT = 0
) (
  input  logic     CLK,
  input  logic     RST,
  input  logic     ex_valid,
  input  logic     ex_regWEN,
  input  regbits_t ex_wsel,
  input  word_t    ex_port_o,
  input  word_t    ex_store,
  input  logic     ex_dREN,
  input  logic     ex_dWEN,
  input  logic     ex_halt,
  input  logic     flush,
  input  logic     dhit,
  input  word_t    dmemload,
  output logic     dmemREN,
  output logic     dmemWEN,
  output word_t    dmemaddr,
  output word_t    dmemstore,
  output logic     ex_stall,
  output logic     exmem_WEN,
  output regbits_t exmem_wsel,
  output word_t    exmem_port_o,
  output logic     exmem_load,
  output logic     memwb_WEN,
  output regbits_t memwb_wsel,
  output word_t    rfif_wdat,
  output logic     halt,
  output logic     mem_timeout
);
  localparam int CW = WAIT_LIMIT > 0 ? $clog2(WAIT_LIMIT + 1) : 1;
  localparam logic [CW-1:0] LIM = CW'(WAIT_LIMIT);
  exmem_t exmem_q, exmem_d;
  memwb_t memwb_q, memwb_d;
  logic halt_q, halt_d, tmo_q, tmo_d, mem_busy;
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    mem_busy = exmem_q.valid & (exmem_q.dREN | exmem_q.dWEN) & ~dhit;
    exmem_d = mem_busy ? exmem_q : (flush | halt_q) ? '0 :
              exmem_t'{ex_valid, ex_regWEN, ex_wsel, ex_port_o, ex_store, ex_dREN, ex_dWEN, ex_halt};
    memwb_d = (mem_busy | halt_q) ? '0 :
              memwb_t'{exmem_q.valid, exmem_q.regWEN, exmem_q.wsel, exmem_q.dREN ? dmemload : exmem_q.port_o};
    halt_d = halt_q | (~mem_busy & exmem_q.valid & exmem_q.halt);
    cnt_d = (WAIT_LIMIT == 0 || !mem_busy) ? '0 : (cnt_q == LIM) ? cnt_q : cnt_q + 1'b1;
    tmo_d = tmo_q | (WAIT_LIMIT != 0 && cnt_d == LIM);
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      exmem_q <= '0;
      memwb_q <= '0;
      halt_q  <= 1'b0;
      tmo_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      exmem_q <= exmem_d;
      memwb_q <= memwb_d;
      halt_q  <= halt_d;
      tmo_q   <= tmo_d;
      cnt_q   <= cnt_d;
    end
  end
  assign dmemREN      = exmem_q.valid & exmem_q.dREN & ~halt_q;
  assign dmemWEN      = exmem_q.valid & exmem_q.dWEN & ~halt_q;
  assign dmemaddr     = exmem_q.port_o;
  assign dmemstore    = exmem_q.store;
  assign ex_stall     = mem_busy;
  assign exmem_WEN    = exmem_q.valid & exmem_q.regWEN & ~exmem_q.dREN & (|exmem_q.wsel);
  assign exmem_wsel   = exmem_q.wsel;
  assign exmem_port_o = exmem_q.port_o;
  assign exmem_load   = exmem_q.valid & exmem_q.dREN & (|exmem_q.wsel);
  assign memwb_WEN    = memwb_q.valid & memwb_q.regWEN & (|memwb_q.wsel);
  assign memwb_wsel   = memwb_q.wsel;
  assign rfif_wdat    = memwb_q.wdat;
  assign halt         = halt_q;
  assign mem_timeout  = tmo_q;
endmodule

// File: tb/tb_wb_forward_pipe.sv
// tb_wb_forward_pipe: directed stimulus, per-cycle compare against an instruction-level model, plus literal spot checks
module tb_wb_forward_pipe;
  logic CLK = 1'b0, RST;
  logic ex_valid, ex_regWEN, ex_dREN, ex_dWEN, ex_halt, flush, dhit;
  logic [4:0] ex_wsel, exmem_wsel, memwb_wsel;
  logic [31:0] ex_port_o, ex_store, dmemload, dmemaddr, dmemstore, exmem_port_o, rfif_wdat;
  logic dmemREN, dmemWEN, ex_stall, exmem_WEN, exmem_load, memwb_WEN, halt, mem_timeout;
  int checks = 0, errors = 0;

  wb_forward_pipe #(.WAIT_LIMIT(4)) dut (
    .CLK(CLK), .RST(RST), .ex_valid(ex_valid), .ex_regWEN(ex_regWEN), .ex_wsel(ex_wsel),
    .ex_port_o(ex_port_o), .ex_store(ex_store), .ex_dREN(ex_dREN), .ex_dWEN(ex_dWEN),
    .ex_halt(ex_halt), .flush(flush), .dhit(dhit), .dmemload(dmemload),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
    .ex_stall(ex_stall), .exmem_WEN(exmem_WEN), .exmem_wsel(exmem_wsel),
    .exmem_port_o(exmem_port_o), .exmem_load(exmem_load), .memwb_WEN(memwb_WEN),
    .memwb_wsel(memwb_wsel), .rfif_wdat(rfif_wdat), .halt(halt), .mem_timeout(mem_timeout)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the instruction currently in MEM, the write pending in WB, and the halt/timeout status.
  typedef struct {
    bit v, we, rd, wr, h;
    bit [4:0] ws;
    bit [31:0] a, sd;
  } ins_t;
  ins_t mm;
  bit wb_we, hlt, tmo, live;
  bit [4:0] wb_ws;
  bit [31:0] wb_d;
  int busy_cycles;

  function automatic bit is_busy();
    return mm.v && (mm.rd || mm.wr) && !dhit;
  endfunction

  always @(posedge CLK) begin
    bit busy;
    if (RST) begin
      mm = '{default: 0};
      wb_we = 0; wb_ws = 0; wb_d = 0; hlt = 0; tmo = 0; busy_cycles = 0;
      live = 1;
    end else begin
      busy = is_busy();
      wb_we = !busy && !hlt && mm.v && mm.we && mm.ws != 0;
      wb_ws = mm.ws;
      wb_d = mm.rd ? dmemload : mm.a;
      busy_cycles = busy ? busy_cycles + 1 : 0;
      if (busy_cycles >= 4) tmo = 1;
      if (!busy && mm.v && mm.h) hlt = 1;
      else if (!busy) begin
        if (flush || hlt) mm.v = 0;
        else mm = '{ex_valid, ex_regWEN, ex_dREN, ex_dWEN, ex_halt, ex_wsel, ex_port_o, ex_store};
      end
    end
  end

  always @(negedge CLK) if (live) begin
    bit req;
    req = mm.v && (mm.rd || mm.wr) && !hlt;
    chk("ex_stall", {31'b0, ex_stall}, {31'b0, is_busy()});
    chk("dmemREN", {31'b0, dmemREN}, {31'b0, mm.v && mm.rd && !hlt});
    chk("dmemWEN", {31'b0, dmemWEN}, {31'b0, mm.v && mm.wr && !hlt});
    if (req) chk("dmemaddr", dmemaddr, mm.a);
    if (req && mm.wr) chk("dmemstore", dmemstore, mm.sd);
    chk("exmem_WEN", {31'b0, exmem_WEN}, {31'b0, mm.v && mm.we && !mm.rd && mm.ws != 0});
    chk("exmem_load", {31'b0, exmem_load}, {31'b0, mm.v && mm.rd && mm.ws != 0});
    if (mm.v && mm.ws != 0 && (mm.we || mm.rd)) chk("exmem_wsel", {27'b0, exmem_wsel}, {27'b0, mm.ws});
    if (mm.v && mm.we && !mm.rd) chk("exmem_port_o", exmem_port_o, mm.a);
    chk("memwb_WEN", {31'b0, memwb_WEN}, {31'b0, wb_we});
    if (wb_we) chk("memwb_wsel", {27'b0, memwb_wsel}, {27'b0, wb_ws});
    if (wb_we) chk("rfif_wdat", rfif_wdat, wb_d);
    chk("halt", {31'b0, halt}, {31'b0, hlt});
    chk("mem_timeout", {31'b0, mem_timeout}, {31'b0, tmo});
  end

  task automatic step();
    @(posedge CLK);
    #2;
  endtask

  task automatic idle();
    ex_valid = 0; ex_regWEN = 0; ex_wsel = 0; ex_port_o = 0; ex_store = 0;
    ex_dREN = 0; ex_dWEN = 0; ex_halt = 0; flush = 0; dhit = 0; dmemload = 0;
  endtask

  task automatic op(input bit we, input bit [4:0] ws, input bit [31:0] a, input bit [31:0] sd,
                    input bit rd, input bit wr, input bit h);
    ex_valid = 1; ex_regWEN = we; ex_wsel = ws; ex_port_o = a; ex_store = sd;
    ex_dREN = rd; ex_dWEN = wr; ex_halt = h;
  endtask

  initial begin
    RST = 1;
    idle();
    step(); step();
    RST = 0;
    #2;
    chk("rst halt", {31'b0, halt}, 0);
    chk("rst memwb_WEN", {31'b0, memwb_WEN}, 0);
    chk("rst dmemREN", {31'b0, dmemREN}, 0);
    chk("rst mem_timeout", {31'b0, mem_timeout}, 0);
    // ALU op forwarded from EX/MEM, then written back
    op(1, 5, 32'h1234, 0, 0, 0, 0);
    step(); idle(); #2;
    chk("alu exmem_WEN", {31'b0, exmem_WEN}, 1);
    chk("alu exmem_wsel", {27'b0, exmem_wsel}, 5);
    step(); #2;
    chk("alu memwb_WEN", {31'b0, memwb_WEN}, 1);
    chk("alu rfif_wdat", rfif_wdat, 32'h1234);
    // load with three wait cycles
    op(1, 8, 32'h40, 0, 1, 0, 0);
    step(); idle(); #2;
    chk("ld exmem_WEN", {31'b0, exmem_WEN}, 0);
    chk("ld exmem_load", {31'b0, exmem_load}, 1);
    chk("ld dmemaddr", dmemaddr, 32'h40);
    for (int i = 0; i < 3; i++) begin
      chk("ld ex_stall", {31'b0, ex_stall}, 1);
      chk("ld dmemREN", {31'b0, dmemREN}, 1);
      step();
    end
    dhit = 1; dmemload = 32'hCAFE; #2;
    chk("ld stall on dhit", {31'b0, ex_stall}, 0);
    step(); idle(); #2;
    chk("ld memwb_WEN", {31'b0, memwb_WEN}, 1);
    chk("ld rfif_wdat", rfif_wdat, 32'hCAFE);
    chk("ld dmemREN drop", {31'b0, dmemREN}, 0);
    // write to r0 never forwards or writes back
    op(1, 0, 32'h777, 0, 0, 0, 0);
    step(); idle(); #2;
    chk("r0 exmem_WEN", {31'b0, exmem_WEN}, 0);
    step(); #2;
    chk("r0 memwb_WEN", {31'b0, memwb_WEN}, 0);
    // flush during a busy store: store completes, flushed op dropped
    op(0, 0, 32'h80, 32'h55AA, 0, 1, 0);
    step();
    op(1, 9, 32'h999, 0, 0, 0, 0); flush = 1; #2;
    chk("st dmemWEN", {31'b0, dmemWEN}, 1);
    chk("st dmemstore", dmemstore, 32'h55AA);
    chk("st ex_stall", {31'b0, ex_stall}, 1);
    step();
    idle(); dhit = 1; #2;
    chk("st dmemWEN at dhit", {31'b0, dmemWEN}, 1);
    step(); idle(); #2;
    chk("st dmemWEN drop", {31'b0, dmemWEN}, 0);
    chk("st flushed exmem_WEN", {31'b0, exmem_WEN}, 0);
    // flush with no memory op in flight bubbles EX/MEM
    op(1, 10, 32'hAAA, 0, 0, 0, 0); flush = 1;
    step(); idle(); #2;
    chk("fl exmem_WEN", {31'b0, exmem_WEN}, 0);
    step(); #2;
    chk("fl memwb_WEN", {31'b0, memwb_WEN}, 0);
    // halt reaches WB two edges later; afterwards no requests
    op(0, 0, 0, 0, 0, 0, 1);
    step(); idle(); #2;
    chk("halt after 1 edge", {31'b0, halt}, 0);
    step(); #2;
    chk("halt after 2 edges", {31'b0, halt}, 1);
    op(1, 3, 32'h44, 0, 1, 0, 0);
    step(); idle(); #2;
    chk("halt dmemREN", {31'b0, dmemREN}, 0);
    chk("halt exmem_load", {31'b0, exmem_load}, 0);
    RST = 1;
    step(); RST = 0; #2;
    chk("halt cleared", {31'b0, halt}, 0);
    // wait timeout after four busy cycles, sticky past dhit
    op(1, 4, 32'h100, 0, 1, 0, 0);
    step(); idle(); #2;
    for (int i = 0; i < 4; i++) begin
      chk("to before limit", {31'b0, mem_timeout}, 0);
      step();
    end
    chk("to at limit", {31'b0, mem_timeout}, 1);
    step();
    dhit = 1; dmemload = 32'hBEEF;
    step(); idle(); #2;
    chk("to sticky", {31'b0, mem_timeout}, 1);
    chk("to load wdat", rfif_wdat, 32'hBEEF);
    // reset in the middle of a wait
    op(1, 6, 32'h200, 0, 1, 0, 0);
    step(); idle(); step();
    RST = 1;
    step(); #2;
    chk("rst dmemREN mid", {31'b0, dmemREN}, 0);
    chk("rst ex_stall mid", {31'b0, ex_stall}, 0);
    chk("rst timeout mid", {31'b0, mem_timeout}, 0);
    chk("rst memwb mid", {31'b0, memwb_WEN}, 0);
    RST = 0;
    step(); step();
    #4;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
